router_sync_ctrl: RTL

Port-side controller for the 1-to-3 packet router. It sits between the router FSM and the three output FIFOs, and does four things:
- Latches the destination address on detect_add.
- Steers the FSM's single write enable to the addressed FIFO and muxes that FIFO's full flag back to the FSM.
- Drives per-port vld_out from the FIFO empty flags.
- Times out unread output ports, emitting a one-cycle soft_reset that flushes the stalled FIFO and aborts the FSM.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_sync_ctrl_if.sv | 34 +++
 rtl/router_timeout_cnt.sv | 44 ++++
 rtl/router_sync_ctrl.sv | 73 +++++++
 4 files changed

// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared constants and types for the router port-side controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;
    localparam int NUM_PORTS       = 3;
    localparam int TIMEOUT_DEFAULT = 30;
    localparam int CNT_W           = 5;

    typedef logic [1:0] port_idx_t;

    // 2'b11 is the reserved "no destination" code; packets addressed to it are dropped.
    localparam port_idx_t ADDR_NONE = 2'b11;
endpackage

`default_nettype wire

// File: rtl/router_sync_ctrl_if.sv
// ============================================================================
// Module      : router_sync_ctrl_if
// Description : FSM/FIFO-side signal bundle for the router sync controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface router_sync_ctrl_if;
    import router_pkg::*;

    logic                 detect_add;
    logic [1:0]           data_in;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_valid;

    modport master (
        output detect_add, data_in, write_enb_reg, read_enb, empty, full,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_valid
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
        output write_enb, fifo_full, vld_out, soft_reset, addr_valid
    );
endinterface

`default_nettype wire

// File: rtl/router_timeout_cnt.sv
// ============================================================================
// Module      : router_timeout_cnt
// Description : Per-port unread-data watchdog producing a one-cycle soft_reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_timeout_cnt #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic vld,
    input  wire logic rd,
    output logic      soft_reset
);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_reset;

    // The pulse cycle itself is the flush cycle and is never counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (r_soft_reset) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign soft_reset = r_soft_reset;
endmodule

`default_nettype wire

// File: rtl/router_sync_ctrl.sv
// ============================================================================
// Module      : router_sync_ctrl
// Description : Address latch, write steering and per-port timeout for the router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT,
    parameter int CNT_W   = router_pkg::CNT_W
) (
    input  wire logic          clock,
    input  wire logic          reset,
    router_sync_ctrl_if.slave  bus
);
    port_idx_t            r_addr;
    logic                 w_addr_valid;
    logic                 w_sr_hit;
    logic                 w_fifo_full;
    logic [NUM_PORTS-1:0] w_write_enb;
    logic [NUM_PORTS-1:0] w_vld;
    logic [NUM_PORTS-1:0] w_soft_reset;

    assign w_addr_valid = (r_addr != ADDR_NONE);
    assign w_vld        = ~bus.empty;

    // Loop decode keeps the reserved code from ever indexing past the port range.
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        w_sr_hit    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_addr_valid && (r_addr == port_idx_t'(i))) begin
                w_write_enb[i] = bus.write_enb_reg;
                w_fifo_full    = bus.full[i];
                w_sr_hit       = w_soft_reset[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr <= ADDR_NONE;
        end else if (bus.detect_add) begin
            r_addr <= bus.data_in;
        end else if (w_sr_hit) begin
            r_addr <= ADDR_NONE;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        router_timeout_cnt #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timeout (
            .clock      (clock),
            .reset      (reset),
            .vld        (w_vld[g]),
            .rd         (bus.read_enb[g]),
            .soft_reset (w_soft_reset[g])
        );
    end

    assign bus.write_enb  = w_write_enb;
    assign bus.fifo_full  = w_fifo_full;
    assign bus.vld_out    = w_vld;
    assign bus.soft_reset = w_soft_reset;
    assign bus.addr_valid = w_addr_valid;
endmodule

`default_nettype wire
